rule_fire_scheduler: RTL and testbench

//   Chooses which guarded rule of the protocol datapath (`system`) fires each cycle and drives its
//   io_en_a rule-select input. The choice is round-robin and fair over rules whose guards are true.
//   The block also detects deadlock (no rule enabled) and starvation (an enabled rule never picked).
//   It sits between the rule-guard logic and the `system` instance in the closed-loop harness.

---
 rtl/sched_pkg.sv | 17 +
 rtl/rr_pick.sv | 40 ++++
 rtl/rule_fire_scheduler.sv | 122 ++++++++++++
 tb/tb_rule_fire_scheduler.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and defaults for the rule-fire scheduler: FSM encoding and rule-index sizing.
package sched_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PAUSED   = 2'd1,
        DEADLOCK = 2'd2
    } sched_state_e;

    function automatic int idx_w_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int NUM_RULES_DEF = 6;
    localparam int IDX_W_DEF     = idx_w_for(NUM_RULES_DEF);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set guard at or after ptr, wrapping.
module rr_pick
    import sched_pkg::*;
#(
    parameter int NUM_RULES = NUM_RULES_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic [NUM_RULES-1:0] guard_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     pick_o,
    output logic                 any_o
);

    localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_RULES);

    logic [NUM_RULES-1:0] cand;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;
    logic [IDX_W:0]       wrapped;
    logic                 found;

    // cand[0] is the guard at ptr, cand[k] the guard k slots later
    assign cand  = (guard_i >> ptr_i) | (guard_i << (NUM_RULES - int'(ptr_i)));
    assign any_o = |guard_i;

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_RULES; k++) begin
            if (!found && cand[k]) begin
                found = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum     = {1'b0, ptr_i} + {1'b0, off};
        wrapped = (sum >= NR) ? (sum - NR) : sum;
        pick_o  = wrapped[IDX_W-1:0];
    end

endmodule

// File: rtl/rule_fire_scheduler.sv
// Fair round-robin rule-fire scheduler with deadlock detection, starvation flag and fire counter.
module rule_fire_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_RULES    = NUM_RULES_DEF,
    parameter int IDX_W        = idx_w_for(NUM_RULES),
    parameter int DEADLOCK_LIM = 8,
    parameter int STARVE_LIM   = 16,
    parameter int CNT_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_RULES-1:0] io_guard,
    input  logic                 io_pause,
    input  logic                 io_clear,
    output logic [IDX_W-1:0]     io_en_a,
    output logic                 io_en_valid,
    output logic                 io_deadlock,
    output logic                 io_starve,
    output logic [CNT_W-1:0]     io_fire_cnt
);

    localparam int IDLE_W = $clog2(DEADLOCK_LIM + 1);
    localparam int WAIT_W = $clog2(STARVE_LIM + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(DEADLOCK_LIM);
    localparam logic [IDLE_W-1:0] IDLE_TRIG = IDLE_W'(DEADLOCK_LIM - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIM);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_RULES - 1);

    sched_state_e state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [NUM_RULES-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic              starve_q, starve_d;
    logic              deadlock_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0]     pick;
    logic                 any;
    logic                 fire;
    logic [NUM_RULES-1:0] fire_oh;
    logic [NUM_RULES-1:0] at_lim;

    rr_pick #(
        .NUM_RULES (NUM_RULES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .guard_i (io_guard),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .any_o   (any)
    );

    // Reset gates the fire path directly so nothing leaks out during the reset cycle itself
    assign fire        = ~reset & (state_q == RUN) & ~io_pause & any;
    assign io_en_valid = fire;
    assign io_en_a     = fire ? pick : '0;
    assign io_deadlock = ~reset & deadlock_q;
    assign io_starve   = starve_q;
    assign io_fire_cnt = cnt_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idle_d   = idle_q;
        wait_d   = wait_q;
        cnt_d    = cnt_q;
        fire_oh  = '0;
        at_lim   = '0;

        if (fire) begin
            ptr_d = (pick == LAST_IDX) ? '0 : pick + IDX_W'(1);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            RUN: begin
                if (io_pause)                            state_d = PAUSED;
                else if (idle_q == IDLE_TRIG && !any)    state_d = DEADLOCK;
            end
            PAUSED:   if (!io_pause) state_d = RUN;
            DEADLOCK: if (io_clear)  state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (state_q == RUN && !any && idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
        if (fire || io_clear || (state_q == RUN && io_pause)) idle_d = '0;

        // Waits only move in RUN; PAUSED and DEADLOCK freeze them
        for (int i = 0; i < NUM_RULES; i++) begin
            fire_oh[i] = fire && (pick == IDX_W'(i));
            at_lim[i]  = (wait_q[i] == WAIT_MAX);
            if (state_q == RUN) begin
                if (!io_guard[i] || fire_oh[i]) wait_d[i] = '0;
                else if (!at_lim[i])            wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
        end

        starve_d = io_clear ? 1'b0 : (starve_q | (|at_lim));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            ptr_q      <= '0;
            idle_q     <= '0;
            wait_q     <= '0;
            starve_q   <= 1'b0;
            deadlock_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idle_q     <= idle_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            deadlock_q <= (state_d == DEADLOCK);
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rule_fire_scheduler.sv
// Directed bench for rule_fire_scheduler with a queue-based scoreboard of expected picks.
module tb_rule_fire_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  io_guard = '0;
    logic        io_pause = 1'b0;
    logic        io_clear = 1'b0;
    logic [2:0]  io_en_a;
    logic        io_en_valid;
    logic        io_deadlock;
    logic        io_starve;
    logic [15:0] io_fire_cnt;

    rule_fire_scheduler #(
        .NUM_RULES    (6),
        .IDX_W        (3),
        .DEADLOCK_LIM (8),
        .STARVE_LIM   (16),
        .CNT_W        (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_guard    (io_guard),
        .io_pause    (io_pause),
        .io_clear    (io_clear),
        .io_en_a     (io_en_a),
        .io_en_valid (io_en_valid),
        .io_deadlock (io_deadlock),
        .io_starve   (io_starve),
        .io_fire_cnt (io_fire_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic       v;
        logic [2:0] a;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One cycle: drive at negedge, queue the expected pick, compare once outputs settle
    task automatic cyc(input logic [5:0] g, input logic p, input logic c, input logic r,
                       input logic ev, input logic [2:0] ea, input string tag);
        exp_t e;
        @(negedge clock);
        io_guard = g;
        io_pause = p;
        io_clear = c;
        reset    = r;
        sb.push_back('{tag, ev, ea});
        #1;
        e = sb.pop_front();
        check({e.tag, ".valid"}, 32'(io_en_valid), 32'(e.v));
        check({e.tag, ".en_a"},  32'(io_en_a),     32'(e.a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // reset: guards high must not fire
        cyc(6'h3f, 0, 0, 1, 0, 3'd0, "rst0");
        check("rst_deadlock", 32'(io_deadlock), 32'd0);
        cyc(6'h3f, 0, 0, 1, 0, 3'd0, "rst1");
        check("rst_cnt",    32'(io_fire_cnt), 32'd0);
        check("rst_starve", 32'(io_starve),   32'd0);

        // 1: two guards alternate
        cyc(6'b000110, 0, 0, 0, 1, 3'd1, "t1_a");
        cyc(6'b000110, 0, 0, 0, 1, 3'd2, "t1_b");
        cyc(6'b000110, 0, 0, 0, 1, 3'd1, "t1_c");
        cyc(6'b000110, 0, 0, 0, 1, 3'd2, "t1_d");

        // 2: drive ptr to 5, then wrap to rule 0
        cyc(6'b010000, 0, 0, 0, 1, 3'd4, "t2_to5");
        check("t1_cnt", 32'(io_fire_cnt), 32'd4);
        cyc(6'b000001, 0, 0, 0, 1, 3'd0, "t2_wrap");
        cyc(6'b111111, 0, 0, 0, 1, 3'd1, "t2_ptr1");
        check("t2_cnt", 32'(io_fire_cnt), 32'd6);

        // 3: eight idle cycles -> deadlock on the ninth
        for (int k = 0; k < 8; k++) begin
            cyc(6'b000000, 0, 0, 0, 0, 3'd0, $sformatf("t3_idle%0d", k));
            check($sformatf("t3_nodl%0d", k), 32'(io_deadlock), 32'd0);
        end
        cyc(6'h3f, 0, 0, 0, 0, 3'd0, "t3_dl");
        check("t3_dl_flag", 32'(io_deadlock), 32'd1);
        cyc(6'h00, 0, 0, 0, 0, 3'd0, "t3_dl_hold");
        check("t3_dl_hold_flag", 32'(io_deadlock), 32'd1);
        cyc(6'h3f, 0, 1, 0, 0, 3'd0, "t3_clr");
        check("t3_clr_flag", 32'(io_deadlock), 32'd1);
        cyc(6'h3f, 0, 0, 0, 1, 3'd2, "t3_run");
        check("t3_run_flag", 32'(io_deadlock), 32'd0);

        // 4: pause holds ptr and count; one PAUSED cycle after drop, then pick resumes at ptr=3
        for (int k = 0; k < 3; k++) cyc(6'h3f, 1, 0, 0, 0, 3'd0, $sformatf("t4_pause%0d", k));
        cyc(6'h3f, 0, 0, 0, 0, 3'd0, "t4_exit");
        check("t4_cnt", 32'(io_fire_cnt), 32'd8);
        cyc(6'h3f, 0, 0, 0, 1, 3'd3, "t4_resume");

        // 6: ptr=4, cnt=10, then reset mid-run
        cyc(6'b001000, 0, 0, 0, 1, 3'd3, "t6_fire3");
        cyc(6'h3f, 0, 0, 1, 0, 3'd0, "t6_rst");
        check("t6_cnt_pre", 32'(io_fire_cnt), 32'd10);
        check("t6_rst_dl",  32'(io_deadlock), 32'd0);
        cyc(6'h3f, 0, 0, 1, 0, 3'd0, "t6_rst2");
        check("t6_cnt_rst", 32'(io_fire_cnt), 32'd0);
        cyc(6'h3f, 0, 0, 0, 1, 3'd0, "t6_ptr0");

        // 5: pin ptr at 4 so rule 3 waits with its guard high
        cyc(6'b000000, 0, 0, 0, 0, 3'd0, "t5_prep");
        check("t6_cnt_post", 32'(io_fire_cnt), 32'd1);
        force dut.ptr_q = 3'd4;
        for (int k = 0; k < 17; k++) cyc(6'b011000, 0, 0, 0, 1, 3'd4, $sformatf("t5_f%0d", k));
        check("t5_pre", 32'(io_starve), 32'd0);
        cyc(6'b011000, 0, 0, 0, 1, 3'd4, "t5_f17");
        check("t5_set", 32'(io_starve), 32'd1);
        release dut.ptr_q;
        cyc(6'b000000, 0, 0, 0, 0, 3'd0, "t5_hold");
        check("t5_sticky", 32'(io_starve), 32'd1);
        cyc(6'b000000, 0, 1, 0, 0, 3'd0, "t5_clr");
        check("t5_clr_same", 32'(io_starve), 32'd1);
        cyc(6'b000000, 0, 0, 0, 0, 3'd0, "t5_after");
        check("t5_cleared", 32'(io_starve), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
